// File: rtl/tt_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and
// helpers that derive the digit count and digit-counter width from WIDTH/DIGIT.
package tt_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A one-digit configuration still needs a 1-bit counter to stay well-formed.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_add_slice.sv
// Combinational DIGIT-bit adder slice. Also exposes the carry into the slice
// MSB so the top can derive signed overflow on the final digit.
module digit_add_slice #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  input  logic             cin,
  output logic [DIGIT-1:0] s_d,
  output logic             cout,
  output logic             c_msb
);

  logic [DIGIT:0] full;

  assign full  = {1'b0, a_d} + {1'b0, b_d} + {{DIGIT{1'b0}}, cin};
  assign s_d   = full[DIGIT-1:0];
  assign cout  = full[DIGIT];
  // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out by XOR.
  assign c_msb = full[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract, LSB digit first, with valid/ready on both sides.
// Optional signed saturation of the result: define DIGIT_SERIAL_ADDER_SATURATE_EN.
module digit_serial_adder
  import tt_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_width(NDIG);

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
    $error("digit_serial_adder: DIGIT must be >= 1 and divide WIDTH");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
`ifdef DIGIT_SERIAL_ADDER_SATURATE_EN
  logic             a_msb_q, a_msb_d;
`endif

  logic [DIGIT-1:0] slice_s;
  logic             slice_cout;
  logic             slice_cmsb;

  digit_add_slice #(.DIGIT(DIGIT)) u_slice (
    .a_d   (a_q[DIGIT-1:0]),
    .b_d   (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .s_d   (slice_s),
    .cout  (slice_cout),
    .c_msb (slice_cmsb)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
`ifdef DIGIT_SERIAL_ADDER_SATURATE_EN
    a_msb_d   = a_msb_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = ST_BUSY;
`ifdef DIGIT_SERIAL_ADDER_SATURATE_EN
          a_msb_d = a[WIDTH-1];
`endif
        end
      end
      ST_BUSY: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NDIG - 1)) begin
          cnt_d   = '0;
          cout_d  = slice_cout;
          ovf_d   = slice_cmsb ^ slice_cout;
          state_d = ST_DONE;
`ifdef DIGIT_SERIAL_ADDER_SATURATE_EN
          if (slice_cmsb ^ slice_cout) begin
            sum_d = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          end
`endif
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_SATURATE_EN
      a_msb_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
`ifdef DIGIT_SERIAL_ADDER_SATURATE_EN
      a_msb_q <= a_msb_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder (WIDTH=8, DIGIT=2) with a result
// scoreboard; honours DIGIT_SERIAL_ADDER_SATURATE_EN in its reference model.
module tb_digit_serial_adder;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             sub_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_in),
    .b         (b_in),
    .sub       (sub_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer arithmetic, independent of the RTL's serial datapath.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic sv);
    exp_t e;
    int   ua, ub, sa, sb, r, sr;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    r  = sv ? (ua - ub) : (ua + ub);
    sr = sv ? (sa - sb) : (sa + sb);
    e.sum  = WIDTH'(r);
    e.cout = sv ? (ua >= ub) : (r > 255);
    e.ovf  = (sr > 127) || (sr < -128);
`ifdef DIGIT_SERIAL_ADDER_SATURATE_EN
    if (e.ovf) e.sum = (sa >= 0) ? 8'h7F : 8'h80;
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One full transaction; hold = cycles to keep out_ready low while in DONE.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic sv, input int hold);
    exp_t e;
    int   n;
    exp_q.push_back(model(av, bv, sv));
    out_ready = (hold == 0);
    @(negedge clk);
    a_in = av; b_in = bv; sub_in = sv; in_valid = 1'b1;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a_in = '0; b_in = '0; sub_in = 1'b0;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid) break;
    end
    check("latency", 32'(n), 32'(NDIG));
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check("hold_sum", 32'(sum), 32'(e.sum));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    check("out_valid", 32'(out_valid), 32'd1);
    check("sum", 32'(sum), 32'(e.sum));
    check("cout", 32'(cout), 32'(e.cout));
    check("ovf", 32'(ovf), 32'(e.ovf));
    $display("op a=%h b=%h sub=%b hold=%0d -> sum=%h cout=%b ovf=%b (exp %h %b %b)",
             av, bv, sv, hold, sum, cout, ovf, e.sum, e.cout, e.ovf);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; sub_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);

    run_op(8'h5A, 8'h33, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    run_op(8'h10, 8'h20, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 5);
    run_op(8'h23, 8'h45, 1'b0, 0);

    // Reset during BUSY discards the operation.
    @(negedge clk);
    a_in = 8'h11; b_in = 8'h22; sub_in = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    $display("reset mid-op -> in_ready=%b out_valid=%b sum=%h", in_ready, out_valid, sum);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_cout", 32'(cout), 32'd0);
    check("mid_rst_ovf", 32'(ovf), 32'd0);

    run_op(8'h01, 8'h02, 1'b0, 0);
    run_op(8'h00, 8'h01, 1'b1, 0);
    run_op(8'h80, 8'h80, 1'b0, 2);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
